lcd_fb_reader: RTL and testbench

LCD_FB_READER -- requirements
Module: lcd_fb_reader

---
 rtl/lcd_fb_reader.sv | 155 +++++++++++++++
 tb/tb_lcd_fb_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fb_reader.sv
// lcd_fb_reader: scans a framebuffer in raster order and drives an RGB888
// parallel LCD (DE + active-low HSYNC/VSYNC). Reads are issued one pixel tick
// ahead of the registered video outputs so the returned RGB565 word and the
// delayed timing leave the block on the same tick.
module lcd_fb_reader #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        i_Clk_en,
    input  logic        i_run,
    output logic [16:0] o_rd_addr,
    output logic        o_rd_en,
    input  logic [15:0] i_rd_data,
    output logic [23:0] o_rgb888,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sized copies of the timing points so counter compares stay width-exact.
    localparam logic [9:0] H_ACT_C      = 10'(H_ACTIVE);
    localparam logic [9:0] H_ACT_LAST_C = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_LAST_C     = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_BEG_C     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END_C     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [8:0] V_ACT_C      = 9'(V_ACTIVE);
    localparam logic [8:0] V_ACT_LAST_C = 9'(V_ACTIVE - 1);
    localparam logic [8:0] V_LAST_C     = 9'(V_TOTAL - 1);
    localparam logic [8:0] VS_BEG_C     = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0] VS_END_C     = 9'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [8:0]  v_cnt_q, v_cnt_d;
    logic [16:0] addr_q, addr_d;

    logic        de_q, hsync_q, vsync_q, fstart_q;
    logic [23:0] rgb_q;

    logic        running;
    logic        active_raw;
    logic        hsync_raw;
    logic        vsync_raw;
    logic        fstart_raw;
    logic        last_active;
    logic [23:0] rgb_expand;

    // Raw (undelayed) timing decoded from the scan position.
    always_comb begin
        running     = (state_q == ST_RUN);
        active_raw  = running && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        hsync_raw   = ~(running && (h_cnt_q >= HS_BEG_C) && (h_cnt_q <= HS_END_C));
        vsync_raw   = ~(running && (v_cnt_q >= VS_BEG_C) && (v_cnt_q <= VS_END_C));
        fstart_raw  = active_raw && (h_cnt_q == 10'd0) && (v_cnt_q == 9'd0);
        last_active = (h_cnt_q == H_ACT_LAST_C) && (v_cnt_q == V_ACT_LAST_C);
        // Replicate the top bits into the low bits so full-scale 565 maps to 0xFF.
        rgb_expand  = {i_rd_data[15:11], i_rd_data[15:13],
                       i_rd_data[10:5],  i_rd_data[10:9],
                       i_rd_data[4:0],   i_rd_data[4:2]};
    end

    // Next-state for the run FSM, scan counters and the running read address.
    // A dropped i_run is only honoured on the very last tick of a frame.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        addr_d  = addr_q;
        if (i_Clk_en) begin
            if (state_q == ST_IDLE) begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                addr_d  = '0;
                if (i_run) begin
                    state_d = ST_RUN;
                end
            end else begin
                if (active_raw) begin
                    addr_d = last_active ? 17'd0 : addr_q + 17'd1;
                end
                if (h_cnt_q == H_LAST_C) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == V_LAST_C) begin
                        v_cnt_d = '0;
                        addr_d  = '0;
                        if (!i_run) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + 9'd1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 10'd1;
                end
            end
        end
    end

    // State, counter and address registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Video outputs delayed one pixel tick; the pixel word is captured on the
    // same edge as DE so colour and timing stay aligned on the LCD bus.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            de_q     <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            fstart_q <= 1'b0;
            rgb_q    <= 24'h000000;
        end else if (i_Clk_en) begin
            de_q     <= active_raw;
            hsync_q  <= hsync_raw;
            vsync_q  <= vsync_raw;
            fstart_q <= fstart_raw;
            rgb_q    <= active_raw ? rgb_expand : 24'h000000;
        end
    end

    assign o_rd_en       = active_raw && i_Clk_en;
    assign o_rd_addr     = addr_q;
    assign o_de          = de_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_frame_start = fstart_q;
    assign o_rgb888      = rgb_q;

endmodule

// File: tb/tb_lcd_fb_reader.sv
// Bench for lcd_fb_reader on a scaled-down panel geometry (15 x 8 ticks).
// The driver pushes the expected output of every enabled tick into a queue;
// a separate monitor pops and compares after each clock edge.
module tb_lcd_fb_reader;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int NPIX  = HA * VA;

    // Framebuffer contents (repeating by addr[2:0]) and hand-expanded RGB888.
    localparam logic [15:0] FB_TAB [0:7] = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410,
                                             16'hFFFF, 16'h0000, 16'h1234, 16'hABCD};
    localparam logic [23:0] RGB_TAB [0:7] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h848284,
                                              24'hFFFFFF, 24'h000000, 24'h1045A5, 24'hAD796B};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        run = 1'b0;
    logic [16:0] rd_addr;
    logic        rd_en;
    logic [15:0] rd_data;
    logic [23:0] rgb;
    logic        de, hs, vs, fs;

    always #5 clk = ~clk;

    // Framebuffer model: garbage whenever no read is strobed, so blanking
    // must be forced to black by the DUT.
    assign rd_data = rd_en ? FB_TAB[rd_addr[2:0]] : 16'hDEAD;

    lcd_fb_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .iClk(clk), .iRst_n(rst_n), .i_Clk_en(en), .i_run(run),
        .o_rd_addr(rd_addr), .o_rd_en(rd_en), .i_rd_data(rd_data),
        .o_rgb888(rgb), .o_de(de), .o_hsync(hs), .o_vsync(vs),
        .o_frame_start(fs)
    );

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        rd_en;
        logic [23:0] rgb;
        logic [16:0] addr;
    } out_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    out_t exp_q[$];
    chk_t chk_q[$];

    int vectors = 0;
    int miscompares = 0;
    int de_total = 0, hs_lo = 0, vs_lo = 0, fs_total = 0, rd_total = 0;
    logic [16:0] last_rd_addr = '0;

    // Driver-side reference state
    bit b_run = 1'b0;
    int n = 0;

    function automatic out_t snap();
        out_t s;
        s.de = de; s.hs = hs; s.vs = vs; s.fs = fs;
        s.rd_en = rd_en; s.rgb = rgb; s.addr = rd_addr;
        return s;
    endfunction

    function automatic out_t idle_exp();
        out_t e;
        e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
        e.rd_en = 1'b0; e.rgb = 24'h0; e.addr = 17'd0;
        return e;
    endfunction

    // Expected behaviour of frame tick k, derived from the raster position.
    function automatic out_t frame_exp(input int k);
        out_t e;
        int h, v, r;
        bit act;
        h = k % HT;
        v = k / HT;
        act = (h < HA) && (v < VA);
        r = v * HA + ((h < HA) ? h : HA);
        e.de    = act;
        e.hs    = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs    = !((v >= VA + VF) && (v < VA + VF + VS));
        e.fs    = (k == 0);
        e.rd_en = act;
        e.rgb   = act ? RGB_TAB[r % 8] : 24'h0;
        e.addr  = (r >= NPIX) ? 17'd0 : 17'(r);
        return e;
    endfunction

    task automatic push_chk(input string nm, input logic [63:0] a, input logic [63:0] x);
        chk_t c;
        c.name = nm; c.act = a; c.exp = x;
        chk_q.push_back(c);
    endtask

    // One pixel-clock cycle of stimulus; the expectation for an enabled edge
    // is queued before the edge happens.
    task automatic tick(input bit en_v, input bit run_v);
        out_t e;
        @(negedge clk);
        en = en_v;
        run = run_v;
        #1;
        if (en_v && rst_n) begin
            if (b_run) begin
                e = frame_exp(n);
                if (n == FRAME - 1) begin
                    n = 0;
                    if (!run_v) b_run = 1'b0;
                end else begin
                    n = n + 1;
                end
            end else begin
                e = idle_exp();
                if (run_v) begin
                    b_run = 1'b1;
                    n = 0;
                end
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] x);
        vectors++;
        if (a !== x) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, a, x, $time);
        end
    endtask

    initial begin : monitor
        out_t pre, post, e;
        chk_t c;
        bit en_s, rst_s;
        forever begin
            @(negedge clk);
            #3;
            pre = snap();
            @(posedge clk);
            en_s = en;
            rst_s = rst_n;
            #1;
            post = snap();
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                cmp(c.name, c.act, c.exp);
            end
            if (rst_s) begin
                if (en_s) begin
                    if (exp_q.size() == 0) begin
                        cmp("sb_underflow", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        cmp("rd_en", 64'(pre.rd_en), 64'(e.rd_en));
                        cmp("rd_addr", 64'(pre.addr), 64'(e.addr));
                        cmp("de", 64'(post.de), 64'(e.de));
                        cmp("hsync", 64'(post.hs), 64'(e.hs));
                        cmp("vsync", 64'(post.vs), 64'(e.vs));
                        cmp("frame_start", 64'(post.fs), 64'(e.fs));
                        cmp("rgb888", 64'(post.rgb), 64'(e.rgb));
                    end
                    de_total += int'(post.de);
                    hs_lo    += int'(!post.hs);
                    vs_lo    += int'(!post.vs);
                    fs_total += int'(post.fs);
                    rd_total += int'(pre.rd_en);
                    if (pre.rd_en) last_rd_addr = pre.addr;
                end else begin
                    cmp("rd_en_when_disabled", 64'(pre.rd_en), 64'd0);
                    cmp("hold_when_disabled", 64'(post), 64'(pre));
                end
            end
        end
    end

    // ---------------- driver ----------------
    int s_de, s_hs, s_vs, s_fs, s_rd;

    task automatic take_snapshot();
        #2;
        s_de = de_total; s_hs = hs_lo; s_vs = vs_lo; s_fs = fs_total; s_rd = rd_total;
    endtask

    task automatic check_frame(input string tag);
        #2;
        push_chk({tag, "_de_ticks"}, 64'(de_total - s_de), 64'(NPIX));
        push_chk({tag, "_hsync_low"}, 64'(hs_lo - s_hs), 64'(HS * VT));
        push_chk({tag, "_vsync_low"}, 64'(vs_lo - s_vs), 64'(VS * HT));
        push_chk({tag, "_frame_starts"}, 64'(fs_total - s_fs), 64'd1);
        push_chk({tag, "_reads"}, 64'(rd_total - s_rd), 64'(NPIX));
        push_chk({tag, "_last_addr"}, 64'(last_rd_addr), 64'(NPIX - 1));
    endtask

    task automatic check_idle_outputs(input string tag);
        push_chk({tag, "_de"}, 64'(de), 64'd0);
        push_chk({tag, "_hsync"}, 64'(hs), 64'd1);
        push_chk({tag, "_vsync"}, 64'(vs), 64'd1);
        push_chk({tag, "_fstart"}, 64'(fs), 64'd0);
        push_chk({tag, "_rgb"}, 64'(rgb), 64'd0);
        push_chk({tag, "_addr"}, 64'(rd_addr), 64'd0);
        push_chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    endtask

    initial begin : driver
        // Reset values while held in reset
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 1: full rate, start-up latency and per-frame totals
        tick(1'b1, 1'b1);
        take_snapshot();
        repeat (FRAME) tick(1'b1, 1'b1);
        check_frame("frame1");

        // Frame 2: pixel tick every other clock
        take_snapshot();
        for (int i = 0; i < 2 * FRAME; i++) tick((i % 2) == 0, 1'b1);
        check_frame("frame2_halfrate");

        // Frame 3: run dropped at line 2; frame must still complete
        take_snapshot();
        for (int i = 0; i < FRAME; i++) tick(1'b1, i < 2 * HT);
        check_frame("frame3_rundrop");
        repeat (3) tick(1'b1, 1'b0);
        #2;
        check_idle_outputs("after_rundrop");

        // Restart, then asynchronous reset part-way through line 1
        tick(1'b1, 1'b1);
        repeat (20) tick(1'b1, 1'b1);
        @(negedge clk);
        push_chk("pre_reset_addr", 64'(rd_addr), 64'd13);
        #1;
        rst_n = 1'b0;
        en = 1'b0;
        b_run = 1'b0;
        n = 0;
        #1;
        check_idle_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Restart after reset: addresses begin again at 0
        tick(1'b1, 1'b1);
        repeat (2 * HT + 3) tick(1'b1, 1'b1);
        repeat (2) tick(1'b0, 1'b1);

        @(negedge clk);
        push_chk("sb_leftover", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
